// File: rtl/card_shoe.sv
// Card source for the blackjack controller: deals pseudo-random cards from one
// tracked 52-card deck without replacement, reshuffling when low or on request.
module card_shoe #(
  parameter int RESHUFFLE_AT = 0,
  parameter int ACE_VALUE    = 11
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [4:0] seed_i,
  input  logic       load_seed_i,
  input  logic       draw_req_i,
  input  logic       shuffle_req_i,
  output logic [4:0] card_out_o,
  output logic       card_valid_o,
  output logic       busy_o,
  output logic [5:0] cards_left_o,
  output logic       shuffled_o
);

  typedef enum logic [1:0] {IDLE, SHUFFLE, DRAW, EMIT} state_t;

  state_t     state_q;
  logic       pending_q;
  logic [4:0] lfsr_q;
  logic [4:0] lfsr_d;
  logic [4:0] card_out_q;
  logic [4:0] card_d;
  logic       card_valid_q;
  logic       shuffled_q;
  logic [5:0] cards_left_q;
  logic [2:0] cnt_q [13];
  logic [3:0] rank;
  logic       accept;
  logic       low_deck;

  always_comb begin
    rank     = lfsr_q[3:0];
    lfsr_d   = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    accept   = 1'b0;
    if (rank <= 4'd12) accept = (cnt_q[rank] != 3'd0);
    low_deck = (cards_left_q <= 6'(RESHUFFLE_AT));
    // Ranks 9..12 are 10/J/Q/K: same value, separate counters.
    card_d = 5'd10;
    if (rank == 4'd0)      card_d = 5'(ACE_VALUE);
    else if (rank <= 4'd8) card_d = {1'b0, rank} + 5'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      lfsr_q       <= 5'b00001;
      card_out_q   <= 5'd0;
      card_valid_q <= 1'b0;
      shuffled_q   <= 1'b0;
      cards_left_q <= 6'd52;
      for (int i = 0; i < 13; i++) cnt_q[i] <= 3'd4;
    end else begin
      card_valid_q <= 1'b0;
      shuffled_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // Seed lands on this edge so a same-cycle draw starts from it.
          if (load_seed_i) lfsr_q <= (seed_i == 5'd0) ? 5'b00001 : seed_i;
          if (shuffle_req_i) begin
            pending_q <= 1'b0;
            state_q   <= SHUFFLE;
          end else if (draw_req_i) begin
            pending_q <= low_deck;
            state_q   <= low_deck ? SHUFFLE : DRAW;
          end
        end
        SHUFFLE: begin
          for (int i = 0; i < 13; i++) cnt_q[i] <= 3'd4;
          cards_left_q <= 6'd52;
          shuffled_q   <= 1'b1;
          pending_q    <= 1'b0;
          state_q      <= pending_q ? DRAW : IDLE;
        end
        DRAW: begin
          lfsr_q <= lfsr_d;
          if (accept) begin
            cnt_q[rank]  <= cnt_q[rank] - 3'd1;
            cards_left_q <= cards_left_q - 6'd1;
            card_out_q   <= card_d;
            state_q      <= EMIT;
          end
        end
        EMIT: begin
          card_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign card_out_o   = card_out_q;
  assign card_valid_o = card_valid_q;
  assign busy_o       = (state_q != IDLE);
  assign cards_left_o = cards_left_q;
  assign shuffled_o   = shuffled_q;

endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe against a deck-level reference model.
module tb_card_shoe;
  localparam int RESHUFFLE = 0;
  localparam int ACE       = 11;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic [4:0] seed_i = 5'd0;
  logic       load_seed_i = 1'b0;
  logic       draw_req_i = 1'b0;
  logic       shuffle_req_i = 1'b0;
  logic [4:0] card_out_o;
  logic       card_valid_o;
  logic       busy_o;
  logic [5:0] cards_left_o;
  logic       shuffled_o;

  card_shoe #(.RESHUFFLE_AT(RESHUFFLE), .ACE_VALUE(ACE)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .seed_i(seed_i), .load_seed_i(load_seed_i),
    .draw_req_i(draw_req_i), .shuffle_req_i(shuffle_req_i), .card_out_o(card_out_o),
    .card_valid_o(card_valid_o), .busy_o(busy_o), .cards_left_o(cards_left_o),
    .shuffled_o(shuffled_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference deck: per-rank remaining counts, LFSR as an integer, cards left.
  int m_cnt [13];
  int m_lfsr;
  int m_left;
  int hist [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lstep(input int l);
    return ((l << 1) & 31) | (((l >> 4) ^ (l >> 2)) & 1);
  endfunction

  function automatic int rank_value(input int r);
    if (r == 0) return ACE;
    if (r <= 8) return r + 1;
    return 10;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 13; i++) m_cnt[i] = 4;
    m_lfsr = 1;
    m_left = 52;
  endtask

  task automatic model_draw(input bit ld, input int s, output int val, output int rej, output int sh);
    if (ld) m_lfsr = (s == 0) ? 1 : s;
    sh = (m_left <= RESHUFFLE) ? 1 : 0;
    if (sh != 0) begin
      for (int i = 0; i < 13; i++) m_cnt[i] = 4;
      m_left = 52;
    end
    rej = 0;
    while ((m_lfsr & 15) > 12 || m_cnt[m_lfsr & 15] == 0) begin
      m_lfsr = lstep(m_lfsr);
      rej++;
    end
    val = rank_value(m_lfsr & 15);
    m_cnt[m_lfsr & 15]--;
    m_left--;
    m_lfsr = lstep(m_lfsr);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    draw_req_i = 1'b0; shuffle_req_i = 1'b0; load_seed_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
  endtask

  task automatic do_draw(input bit ld, input int s, input string tag);
    int val, rej, sh, n;
    bit saw_sh;
    @(negedge clk_i);
    draw_req_i = 1'b1; load_seed_i = ld; seed_i = 5'(s);
    model_draw(ld, s, val, rej, sh);
    @(negedge clk_i);
    draw_req_i = 1'b0; load_seed_i = 1'b0;
    chk({tag, "_busy"}, busy_o, 1);
    n = 0; saw_sh = 0;
    while (card_valid_o !== 1'b1 && n < 100) begin
      if (shuffled_o === 1'b1) saw_sh = 1;
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_valid"}, card_valid_o, 1);
    chk({tag, "_latency"}, n, 2 + rej + sh);
    chk({tag, "_card"}, card_out_o, val);
    chk({tag, "_left"}, cards_left_o, m_left);
    chk({tag, "_shuffled"}, saw_sh, sh);
    chk({tag, "_idle"}, busy_o, 0);
    if (card_out_o < 32) hist[card_out_o]++;
    @(negedge clk_i);
    chk({tag, "_pulse"}, card_valid_o, 0);
  endtask

  task automatic do_shuffle(input string tag);
    @(negedge clk_i);
    shuffle_req_i = 1'b1;
    for (int i = 0; i < 13; i++) m_cnt[i] = 4;
    m_left = 52;
    @(negedge clk_i);
    shuffle_req_i = 1'b0;
    chk({tag, "_busy"}, busy_o, 1);
    @(negedge clk_i);
    chk({tag, "_pulse"}, shuffled_o, 1);
    chk({tag, "_left"}, cards_left_o, 52);
    @(negedge clk_i);
    chk({tag, "_pulse_end"}, shuffled_o, 0);
  endtask

  initial begin
    int pulses;
    int op;

    // Reset state
    do_reset();
    chk("rst_card", card_out_o, 0);
    chk("rst_valid", card_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_left", cards_left_o, 52);
    chk("rst_shuffled", shuffled_o, 0);

    // First three draws from the reset LFSR
    do_draw(0, 0, "d1");
    chk("d1_const", card_out_o, 2);
    do_draw(0, 0, "d2");
    chk("d2_const", card_out_o, 3);
    do_draw(0, 0, "d3");
    chk("d3_const", card_out_o, 5);
    chk("d3_left_const", cards_left_o, 49);

    // Seed 01101 rejects rank 13 once, then lands on rank 11
    do_draw(1, 13, "seed13");
    chk("seed13_const", card_out_o, 10);

    // Seed 0 maps to 00001
    do_draw(1, 0, "seed0");
    chk("seed0_const", card_out_o, 2);

    // Randomized mix of draws, seed loads and shuffles
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 9);
      if (op == 0) do_shuffle("rnd_shuf");
      else if (op <= 2) do_draw(1, $urandom_range(0, 31), "rnd_seeddraw");
      else do_draw(0, 0, "rnd_draw");
    end

    // Exhaust the deck, then the 53rd draw auto-shuffles
    do_reset();
    for (int v = 0; v < 32; v++) hist[v] = 0;
    for (int i = 0; i < 52; i++) do_draw(0, 0, "deck");
    chk("deck_empty", cards_left_o, 0);
    for (int v = 2; v <= 9; v++) chk("hist_num", hist[v], 4);
    chk("hist_ten", hist[10], 16);
    chk("hist_ace", hist[ACE], 4);
    do_draw(0, 0, "auto");
    chk("auto_left_const", cards_left_o, 51);

    // Reset while in DRAW, then a draw_req held into a busy cycle
    @(negedge clk_i);
    draw_req_i = 1'b1;
    @(negedge clk_i);
    draw_req_i = 1'b0;
    chk("abort_busy", busy_o, 1);
    reset_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      if (card_valid_o === 1'b1) pulses++;
    end
    reset_i = 1'b0;
    model_reset();
    chk("abort_no_pulse", pulses, 0);
    chk("abort_left", cards_left_o, 52);
    chk("abort_busy_clr", busy_o, 0);
    @(negedge clk_i);
    draw_req_i = 1'b1;
    @(negedge clk_i);
    chk("drop_busy", busy_o, 1);
    @(negedge clk_i);
    draw_req_i = 1'b0;
    pulses = (card_valid_o === 1'b1) ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (card_valid_o === 1'b1) pulses++;
    end
    chk("drop_pulses", pulses, 1);
    chk("drop_card", card_out_o, 2);
    chk("drop_left", cards_left_o, 51);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
